// File: rtl/bcd_sseg_scan4_if.sv
// Display-side signal bundle for bcd_sseg_scan4: BCD word and controls in,
// multiplexed segment/anode drive and frame strobe out.
interface bcd_sseg_scan4_if;
    logic [15:0] d;
    logic [3:0]  dp_in;
    logic        en;
    logic        lzb;
    logic        blink;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    modport master (
        output d, dp_in, en, lzb, blink,
        input  seg, dp, an, frame
    );

    modport slave (
        input  d, dp_in, en, lzb, blink,
        output seg, dp, an, frame
    );
endinterface

// File: rtl/bcd_sseg_scan4.sv
// Four-digit multiplexed seven-segment driver (active-low) with leading-zero
// blanking, invalid-digit dash, whole-display blink and per-frame BCD sampling.
module bcd_sseg_scan4 #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_TICKS = 250
) (
    input logic              clk,
    input logic              clr,
    bcd_sseg_scan4_if.slave  bus
);
    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow;
    logic [3:0]    r_shadow_dp;
    logic [BW-1:0] r_bcnt;
    logic          r_phase;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame;

    logic          w_tick;
    logic          w_wrap;
    logic [1:0]    w_idx_nxt;
    logic [15:0]   w_word;
    logic [3:0]    w_dps;
    logic [3:0]    w_digit;
    logic [3:0]    w_blank;
    logic          w_bwrap;
    logic          w_phase_nxt;
    logic          w_dark;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111110;
        endcase
        return s;
    endfunction

    always_comb begin
        w_tick      = (r_presc == PW'(REFRESH_DIV - 1));
        w_wrap      = w_tick && (r_idx == 2'd3);
        w_idx_nxt   = r_idx + 2'd1;
        // The frame's first slot must show the word being loaded on this same edge.
        w_word      = w_wrap ? bus.d : r_shadow;
        w_dps       = w_wrap ? bus.dp_in : r_shadow_dp;
        w_digit     = w_word[{w_idx_nxt, 2'b00} +: 4];
        w_blank[3]  = bus.lzb && (w_word[15:12] == 4'd0);
        w_blank[2]  = w_blank[3] && (w_word[11:8] == 4'd0);
        w_blank[1]  = w_blank[2] && (w_word[7:4] == 4'd0);
        w_blank[0]  = 1'b0;
        w_bwrap     = (r_bcnt == BW'(BLINK_TICKS - 1));
        w_phase_nxt = w_bwrap ? ~r_phase : r_phase;
        w_dark      = !bus.en || (bus.blink && w_phase_nxt) || w_blank[w_idx_nxt];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_presc     <= '0;
            r_idx       <= 2'd3;
            r_shadow    <= 16'h0000;
            r_shadow_dp <= 4'h0;
            r_bcnt      <= '0;
            r_phase     <= 1'b0;
            r_an        <= 4'b1111;
            r_seg       <= 7'b1111111;
            r_dp        <= 1'b1;
            r_frame     <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_frame <= w_wrap;
            if (w_tick) begin
                r_idx   <= w_idx_nxt;
                r_bcnt  <= w_bwrap ? '0 : r_bcnt + 1'b1;
                r_phase <= w_phase_nxt;
                if (w_wrap) begin
                    r_shadow    <= bus.d;
                    r_shadow_dp <= bus.dp_in;
                end
                if (w_dark) begin
                    r_an  <= 4'b1111;
                    r_seg <= 7'b1111111;
                    r_dp  <= 1'b1;
                end else begin
                    r_an  <= ~(4'b0001 << w_idx_nxt);
                    r_seg <= seg_decode(w_digit);
                    r_dp  <= ~w_dps[w_idx_nxt];
                end
            end
        end
    end

    assign bus.an    = r_an;
    assign bus.seg   = r_seg;
    assign bus.dp    = r_dp;
    assign bus.frame = r_frame;
endmodule

// File: tb/tb_bcd_sseg_scan4.sv
// Directed bench for bcd_sseg_scan4 with REFRESH_DIV=4, BLINK_TICKS=2;
// expected anode/segment values are hand-computed per slot.
module tb_bcd_sseg_scan4;
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SD = 7'b1111110;
    localparam logic [6:0] SX = 7'b1111111;

    logic clk;
    logic clr;
    int   n_checks = 0;
    int   n_errs   = 0;

    bcd_sseg_scan4_if bus ();

    bcd_sseg_scan4 #(
        .REFRESH_DIV (4),
        .BLINK_TICKS (2)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp, input logic e_frame);
        check_eq({tag, ".an"}, 32'(bus.an), 32'(e_an));
        check_eq({tag, ".seg"}, 32'(bus.seg), 32'(e_seg));
        check_eq({tag, ".dp"}, 32'(bus.dp), 32'(e_dp));
        check_eq({tag, ".frame"}, 32'(bus.frame), 32'(e_frame));
    endtask

    // Advance exactly one refresh slot and check the new slot's outputs.
    task automatic slot(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                        input logic e_dp, input logic e_frame);
        step(4);
        expect_out(tag, e_an, e_seg, e_dp, e_frame);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr       = 1'b1;
        bus.d     = 16'h1234;
        bus.dp_in = 4'b0000;
        bus.en    = 1'b1;
        bus.lzb   = 1'b0;
        bus.blink = 1'b0;
        #12;
        expect_out("reset", 4'b1111, SX, 1'b1, 1'b0);
        #1 clr = 1'b0;

        // Normal scan, ticks 1..4
        step(3);
        expect_out("pre_tick1", 4'b1111, SX, 1'b1, 1'b0);
        step(1);
        expect_out("tick1", 4'b1110, S4, 1'b1, 1'b1);
        step(1);
        expect_out("tick1_hold", 4'b1110, S4, 1'b1, 1'b0);
        step(3);
        expect_out("tick2", 4'b1101, S3, 1'b1, 1'b0);
        slot("tick3", 4'b1011, S2, 1'b1, 1'b0);
        slot("tick4", 4'b0111, S1, 1'b1, 1'b0);

        // Leading-zero blanking, ticks 5..12
        bus.d   = 16'h0050;
        bus.lzb = 1'b1;
        slot("lzb50_d0", 4'b1110, S0, 1'b1, 1'b1);
        slot("lzb50_d1", 4'b1101, S5, 1'b1, 1'b0);
        slot("lzb50_d2", 4'b1111, SX, 1'b1, 1'b0);
        slot("lzb50_d3", 4'b1111, SX, 1'b1, 1'b0);
        bus.d = 16'h0000;
        slot("lzb00_d0", 4'b1110, S0, 1'b1, 1'b1);
        slot("lzb00_d1", 4'b1111, SX, 1'b1, 1'b0);
        slot("lzb00_d2", 4'b1111, SX, 1'b1, 1'b0);
        slot("lzb00_d3", 4'b1111, SX, 1'b1, 1'b0);

        // Invalid digit and decimal point, ticks 13..16
        bus.lzb   = 1'b0;
        bus.d     = 16'h9A99;
        bus.dp_in = 4'b0100;
        slot("inv_d0", 4'b1110, S9, 1'b1, 1'b1);
        slot("inv_d1", 4'b1101, S9, 1'b1, 1'b0);
        slot("inv_d2", 4'b1011, SD, 1'b0, 1'b0);
        slot("inv_d3", 4'b0111, S9, 1'b1, 1'b0);

        // Coherency: d changes mid-frame, ticks 17..24
        bus.dp_in = 4'b0000;
        bus.d     = 16'h1111;
        slot("coh1_d0", 4'b1110, S1, 1'b1, 1'b1);
        slot("coh1_d1", 4'b1101, S1, 1'b1, 1'b0);
        bus.d = 16'h2222;
        slot("coh1_d2", 4'b1011, S1, 1'b1, 1'b0);
        slot("coh1_d3", 4'b0111, S1, 1'b1, 1'b0);
        slot("coh2_d0", 4'b1110, S2, 1'b1, 1'b1);
        slot("coh2_d1", 4'b1101, S2, 1'b1, 1'b0);
        slot("coh2_d2", 4'b1011, S2, 1'b1, 1'b0);
        slot("coh2_d3", 4'b0111, S2, 1'b1, 1'b0);

        // Blink: phase after tick n is (n/2)%2 -> ticks 26,27 dark
        bus.blink = 1'b1;
        slot("blink_d0", 4'b1110, S2, 1'b1, 1'b1);
        slot("blink_d1", 4'b1111, SX, 1'b1, 1'b0);
        slot("blink_d2", 4'b1111, SX, 1'b1, 1'b0);
        slot("blink_d3", 4'b0111, S2, 1'b1, 1'b0);

        // Enable off: holds until next tick, then dark with frame still pulsing
        bus.blink = 1'b0;
        bus.en    = 1'b0;
        step(2);
        expect_out("en_off_hold", 4'b0111, S2, 1'b1, 1'b0);
        step(2);
        expect_out("en_off_d0", 4'b1111, SX, 1'b1, 1'b1);
        slot("en_off_d1", 4'b1111, SX, 1'b1, 1'b0);
        slot("en_off_d2", 4'b1111, SX, 1'b1, 1'b0);
        slot("en_off_d3", 4'b1111, SX, 1'b1, 1'b0);

        // Async reset mid-slot
        bus.en = 1'b1;
        slot("pre_clr_d0", 4'b1110, S2, 1'b1, 1'b1);
        step(1);
        #3 clr = 1'b1;
        #1;
        expect_out("async_clr", 4'b1111, SX, 1'b1, 1'b0);
        #2 clr = 1'b0;
        step(3);
        expect_out("post_clr_pre", 4'b1111, SX, 1'b1, 1'b0);
        step(1);
        expect_out("post_clr_tick1", 4'b1110, S2, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
